adc_capture_buffer: RTL and testbench

- Triggered snapshot buffer directly downstream of the main ADC IO stage; consumes its registered 14-bit channel A/B samples at the ADC clock (nominally 245.76 MHz).
- Holds a circular block-RAM record of 2^DEPTH_LOG2 sample pairs with a programmable pre-trigger window.
- After capture, streams the record out oldest-first over a valid/ready interface for host readout.

---
 rtl/adc_capture_buffer.sv | 214 +++++++++++++++++++++
 tb/tb_adc_capture_buffer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_buffer.sv
// Triggered snapshot buffer for the dual-channel ADC sample stream.
// Optional trigger timestamp counter: define ADC_CAPTURE_TIMESTAMP_EN.
module adc_capture_buffer #(
    parameter int DEPTH_LOG2 = 10,
    parameter int PRETRIG    = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] adc_a,
    input  logic [13:0] adc_b,
    input  logic        cal_done,
    input  logic        arm,
    input  logic        force_trig,
    input  logic        trig_src,
    input  logic        trig_falling,
    input  logic [13:0] trig_level,
    output logic        busy,
    output logic        triggered,
    output logic        aborted,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [27:0] rd_data,
    output logic        rd_last,
    output logic [31:0] trig_time
);

    localparam int AW     = DEPTH_LOG2;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int POST_N = DEPTH - PRETRIG;
    localparam logic [AW-1:0] PF_LAST   = AW'(PRETRIG - 1);
    localparam logic [AW-1:0] POST_LAST = AW'(POST_N - 1);
    localparam logic [AW:0]   ISS_END   = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, PRE_FILL, ARMED, POST, READOUT
    } state_t;

    state_t state, state_n;

    logic [27:0]   mem [DEPTH];
    logic [27:0]   ram_q;
    logic [AW-1:0] wr_ptr, rd_ptr, cnt;
    logic [AW:0]   iss_cnt;
    logic [13:0]   prev_a, prev_b;
    logic          pend, pend_last;
    logic [28:0]   ent0, ent1;
    logic [1:0]    fcnt, occ;
    logic          arm_ok, abort, trig_hit, rd_done;
    logic          we, pop, issue, edge_hit;
    logic signed [13:0] s_smp, p_smp, lvl;

    assign s_smp = trig_src ? adc_b : adc_a;
    assign p_smp = trig_src ? prev_b : prev_a;
    assign lvl   = trig_level;
    assign edge_hit = trig_falling ? (p_smp > lvl && s_smp <= lvl)
                                   : (p_smp < lvl && s_smp >= lvl);

    assign we       = (state == PRE_FILL) || (state == ARMED) || (state == POST);
    assign busy     = (state != IDLE);
    assign rd_valid = (fcnt != 2'd0);
    assign rd_data  = ent0[27:0];
    assign rd_last  = rd_valid && ent0[28];
    assign pop      = rd_valid && rd_ready;
    // Reads in flight plus buffered words never exceed the two skid slots.
    assign occ      = fcnt + {1'b0, pend};
    assign issue    = (state == READOUT) && (iss_cnt != ISS_END) &&
                      ((occ < 2'd2) || (pop && occ == 2'd2));

    // Next-state and event decode.
    always_comb begin
        state_n  = state;
        arm_ok   = 1'b0;
        abort    = 1'b0;
        trig_hit = 1'b0;
        rd_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (arm && cal_done) begin
                    arm_ok  = 1'b1;
                    state_n = PRE_FILL;
                end
            end
            PRE_FILL: begin
                if (!cal_done) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end else if (cnt == PF_LAST) begin
                    state_n = ARMED;
                end
            end
            ARMED: begin
                if (!cal_done) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end else if (edge_hit || force_trig) begin
                    trig_hit = 1'b1;
                    state_n  = (POST_N == 1) ? READOUT : POST;
                end
            end
            POST: begin
                if (!cal_done) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end else if (cnt == POST_LAST) begin
                    state_n = READOUT;
                end
            end
            READOUT: begin
                if (pop && ent0[28]) begin
                    rd_done = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Pointers, phase counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            iss_cnt   <= '0;
            prev_a    <= '0;
            prev_b    <= '0;
            triggered <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            prev_a <= adc_a;
            prev_b <= adc_b;
            if (we) wr_ptr <= wr_ptr + 1'b1;
            if (state == PRE_FILL || state == POST) cnt <= cnt + 1'b1;
            if (arm_ok) begin
                aborted <= 1'b0;
                cnt     <= '0;
                iss_cnt <= '0;
            end
            if (trig_hit) begin
                triggered <= 1'b1;
                cnt       <= AW'(1);
                rd_ptr    <= wr_ptr - AW'(PRETRIG);
            end
            if (issue) begin
                rd_ptr  <= rd_ptr + 1'b1;
                iss_cnt <= iss_cnt + 1'b1;
            end
            if (abort) begin
                aborted   <= 1'b1;
                triggered <= 1'b0;
            end
            if (rd_done) triggered <= 1'b0;
        end
    end

    // Sample record RAM with registered read port.
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= {adc_b, adc_a};
        if (issue) ram_q <= mem[rd_ptr];
    end

    // Two-entry skid buffer fed by the RAM read pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_last <= 1'b0;
            ent0      <= '0;
            ent1      <= '0;
            fcnt      <= '0;
        end else begin
            pend      <= issue;
            pend_last <= issue && (iss_cnt == ISS_END - 1'b1);
            if (pend && !pop) begin
                if (fcnt == 2'd0) ent0 <= {pend_last, ram_q};
                else              ent1 <= {pend_last, ram_q};
                fcnt <= fcnt + 2'd1;
            end else if (!pend && pop) begin
                ent0 <= ent1;
                fcnt <= fcnt - 2'd1;
            end else if (pend && pop) begin
                if (fcnt == 2'd1) begin
                    ent0 <= {pend_last, ram_q};
                end else begin
                    ent0 <= ent1;
                    ent1 <= {pend_last, ram_q};
                end
            end
        end
    end

`ifdef ADC_CAPTURE_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    // Free-running cycle counter, captured on the trigger cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_cnt    <= '0;
            trig_time <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (trig_hit) trig_time <= ts_cnt;
        end
    end
`else
    assign trig_time = '0;
`endif

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Randomized bench for adc_capture_buffer against a sample-history model.
// The model picks the trigger from recorded samples and slices the record.
module tb_adc_capture_buffer;

    localparam int DEPTH = 1024;
    localparam int PRE   = 64;
    localparam int HN    = 131072;

    logic        clk = 1'b0;
    logic        rst, cal_done, arm, force_trig;
    logic        trig_src, trig_falling, rd_ready;
    logic [13:0] adc_a, adc_b, trig_level;
    logic        busy, triggered, aborted, rd_valid, rd_last;
    logic [27:0] rd_data;
    logic [31:0] trig_time;

    adc_capture_buffer #(.DEPTH_LOG2(10), .PRETRIG(PRE)) dut (
        .clk(clk), .rst(rst), .adc_a(adc_a), .adc_b(adc_b),
        .cal_done(cal_done), .arm(arm), .force_trig(force_trig),
        .trig_src(trig_src), .trig_falling(trig_falling),
        .trig_level(trig_level), .busy(busy), .triggered(triggered),
        .aborted(aborted), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last), .trig_time(trig_time)
    );

    always #2 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [13:0] ha [HN];
    logic [13:0] hb [HN];
    bit          hf [HN];
    int          nedge = 0;
    int          pat = 0;
    int          base = 0;
    int          rst_edge = 0;
    logic [27:0] wd [DEPTH];
    bit          wl [DEPTH];

    // Record what the DUT sees on every edge.
    always @(posedge clk) begin
        if (nedge < HN) begin
            ha[nedge] = adc_a;
            hb[nedge] = adc_b;
            hf[nedge] = force_trig;
        end
        nedge++;
    end

    // Drive the sample stream just after each edge.
    always begin
        @(posedge clk);
        #1;
        case (pat)
            1: begin adc_a = 14'(nedge - base); adc_b = 14'($urandom); end
            2: begin adc_a = 14'($urandom); adc_b = 14'(8191 - (nedge - base)); end
            3: begin adc_a = 14'd123; adc_b = 14'(nedge - base); end
            default: begin adc_a = 14'($urandom); adc_b = 14'($urandom); end
        endcase
    end

    function automatic int find_trig(input int ae, input logic [13:0] lv,
                                     input bit src, input bit fall);
        logic signed [13:0] p, s, l;
        l = lv;
        for (int e = ae + PRE + 1; e < nedge; e++) begin
            p = src ? hb[e-1] : ha[e-1];
            s = src ? hb[e] : ha[e];
            if (hf[e]) return e;
            if (fall && p > l && s <= l) return e;
            if (!fall && p < l && s >= l) return e;
        end
        return -1;
    endfunction

    task automatic arm_pulse(output int ae);
        @(negedge clk);
        arm = 1'b1;
        ae = nedge;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic read_words(input bit stall_mode);
        int n = 0, stall = 0, bad_hold = 0, bad_trig = 0;
        bit done = 0, pv = 0, tog = 0, rdy;
        logic [28:0] pd = '0;
        for (int c = 0; c < 20000 && !done; c++) begin
            @(negedge clk);
            if (pv && (!rd_valid || {rd_last, rd_data} != pd)) bad_hold++;
            if (rd_valid && !triggered) bad_trig++;
            if (!stall_mode) begin
                rdy = 1'b1;
            end else if (stall > 0) begin
                rdy = 1'b0;
                stall--;
            end else if ($urandom_range(0, 15) == 0) begin
                rdy = 1'b0;
                stall = 4;
            end else begin
                tog = ~tog;
                rdy = tog;
            end
            rd_ready = rdy;
            if (rd_valid && rdy) begin
                if (n < DEPTH) begin
                    wd[n] = rd_data;
                    wl[n] = rd_last;
                end
                n++;
                if (rd_last) done = 1;
            end
            pv = rd_valid && !rdy;
            pd = {rd_last, rd_data};
        end
        check("rd_done", done, 1);
        check("rd_count", n, DEPTH);
        check("rd_hold", bad_hold, 0);
        check("trig_hi", bad_trig, 0);
        @(negedge clk);
        rd_ready = 1'b0;
        check("valid_off", rd_valid, 0);
        check("busy_off", busy, 0);
        check("trig_off", triggered, 0);
    endtask

    task automatic verify(input int ae, input logic [13:0] lv,
                          input bit src, input bit fall, output int e);
        logic [27:0] exp;
        e = find_trig(ae, lv, src, fall);
        check("trig_found", e >= 0, 1);
        if (e < 0) return;
        for (int i = 0; i < DEPTH; i++) begin
            exp = {hb[e-PRE+i], ha[e-PRE+i]};
            check($sformatf("word%0d", i), wd[i], exp);
            check($sformatf("last%0d", i), wl[i], i == DEPTH - 1);
        end
`ifdef ADC_CAPTURE_TIMESTAMP_EN
        check("trig_time", trig_time, e - rst_edge);
`else
        check("trig_time", trig_time, 0);
`endif
    endtask

    task automatic check_idle_reset();
        check("rst_busy", busy, 0);
        check("rst_trig", triggered, 0);
        check("rst_abort", aborted, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_last", rd_last, 0);
        check("rst_data", rd_data, 0);
        check("rst_time", trig_time, 0);
    endtask

    initial begin
        int ae, e, fe, dummy, vcnt;
        rst = 1'b1; cal_done = 1'b0; arm = 1'b0; force_trig = 1'b0;
        trig_src = 1'b0; trig_falling = 1'b0; trig_level = '0;
        rd_ready = 1'b0; adc_a = '0; adc_b = '0;
        repeat (4) @(negedge clk);
        check_idle_reset();
        rst = 1'b0;
        rst_edge = nedge;
        cal_done = 1'b1;

        // Rising ramp on channel A.
        pat = 1; base = nedge;
        trig_src = 1'b0; trig_falling = 1'b0; trig_level = 14'd500;
        repeat (3) @(negedge clk);
        arm_pulse(ae);
        check("busy_arm", busy, 1);
        read_words(0);
        verify(ae, trig_level, 0, 0, e);
        check("w0_a", wd[0][13:0], 436);
        check("w64_a", wd[64][13:0], 500);

        // Falling descending ramp on channel B.
        pat = 2; base = nedge;
        trig_src = 1'b1; trig_falling = 1'b1; trig_level = 14'h3F9C;
        repeat (3) @(negedge clk);
        arm_pulse(ae);
        read_words(0);
        verify(ae, trig_level, 1, 1, e);
        check("w64_b", wd[64][27:14], 32'h3F9C);

        // Force trigger on a flat signal.
        pat = 3; base = nedge;
        trig_src = 1'b0; trig_falling = 1'b0; trig_level = 14'd500;
        repeat (3) @(negedge clk);
        arm_pulse(ae);
        while (nedge != ae + PRE + 1 + 200) @(negedge clk);
        force_trig = 1'b1;
        fe = nedge;
        @(negedge clk);
        force_trig = 1'b0;
        read_words(0);
        verify(ae, trig_level, 0, 0, e);
        check("force_edge", e, fe);
        check("w64_force", wd[64], {hb[fe], ha[fe]});

        // Readout under stalls and toggling ready.
        pat = 1; base = nedge;
        repeat (3) @(negedge clk);
        arm_pulse(ae);
        read_words(1);
        verify(ae, trig_level, 0, 0, e);

        // Calibration loss during POST aborts the capture.
        pat = 1; base = nedge;
        repeat (3) @(negedge clk);
        arm_pulse(ae);
        for (int c = 0; c < 5000 && !triggered; c++) @(negedge clk);
        check("trig_wait", triggered, 1);
        repeat (10) @(negedge clk);
        cal_done = 1'b0;
        @(negedge clk);
        check("ab_busy", busy, 0);
        check("ab_flag", aborted, 1);
        check("ab_trig", triggered, 0);
        vcnt = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (rd_valid) vcnt++;
        end
        check("ab_novalid", vcnt, 0);
        arm_pulse(dummy);
        check("nocal_busy", busy, 0);
        check("nocal_abort", aborted, 1);

        // Arm and edge during PRE_FILL are ignored.
        cal_done = 1'b1;
        pat = 1; base = nedge - 480;
        repeat (2) @(negedge clk);
        arm_pulse(ae);
        check("rearm_abort", aborted, 0);
        check("rearm_busy", busy, 1);
        repeat (20) @(negedge clk);
        arm_pulse(dummy);
        check("pf_busy", busy, 1);
        while (nedge < ae + PRE + 1 + 100) @(negedge clk);
        force_trig = 1'b1;
        fe = nedge;
        @(negedge clk);
        force_trig = 1'b0;
        read_words(0);
        verify(ae, trig_level, 0, 0, e);
        check("pf_edge", e, fe);

        // Reset in the middle of a capture.
        pat = 0;
        arm_pulse(ae);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
